// File: rtl/pcie_rc_cpl_rx.sv
// RC completion receiver: skid FIFO between the PCIe core RC stream and the completion assembler.
// Optional macro RC_PARITY_CHK_EN enables per-byte odd-parity checking of accepted beats.
module pcie_rc_cpl_rx #(
  parameter int DWIDTH       = 256,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                          pcie_clk,
  input  logic                          pcie_rst,
  input  logic                          pcie_link_up,
  input  logic [DWIDTH-1:0]             m_axis_rc_tdata,
  input  logic [74:0]                   m_axis_rc_tuser,
  input  logic                          m_axis_rc_tlast,
  input  logic [DWIDTH/32-1:0]          m_axis_rc_tkeep,
  input  logic                          m_axis_rc_tvalid,
  output logic                          m_axis_rc_tready,
  output logic [15:0]                   rc_cplr_data_ex,
  output logic [DWIDTH-1:0]             rc_cplr_data,
  output logic                          rc_cplr_wen,
  input  logic                          rc_cplr_ready,
  output logic [31:0]                   cpl_pkt_cnt,
  output logic [15:0]                   cpl_err_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   odbg_info
);
  localparam int KW     = DWIDTH / 32;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int EW     = DWIDTH + 16;
  localparam int THRESH = FIFO_DEPTH - AFULL_MARGIN;

  typedef enum logic [1:0] {IDLE = 2'd0, IN_PKT = 2'd1} state_e;

  function automatic logic [4:0] keep_mod(input logic [KW-1:0] keep);
    logic [4:0] m;
    m = 5'd0;
    for (int i = 0; i < KW; i++) begin
      if (keep[i]) m = 5'(i);
    end
    return m;
  endfunction

`ifdef RC_PARITY_CHK_EN
  function automatic logic par_mismatch(input logic [DWIDTH-1:0] d, input logic [31:0] p);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DWIDTH / 8; i++) begin
      if (p[i] != ~^d[8*i +: 8]) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  state_e              state_q, state_d;
  logic                err_q;
  logic [7:0]          tag_q;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                tready_q, tready_d;
  logic                wen_q;
  logic [DWIDTH-1:0]   out_data_q;
  logic [15:0]         out_ex_q;
  logic [31:0]         pkt_cnt_q, pkt_cnt_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                ovf_q;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];

  logic                push_s, pop_s, full_s, wr_en_s, ovf_s;
  logic                sof_s, sop_s, frame_err_s, err_s, par_bad_s;
  logic [7:0]          tag_in_s, tag_s;
  logic [15:0]         ex_s, pop_ex_s;
  logic [EW-1:0]       pop_entry_s;
  logic [3:0]          par_cnt_s;
  logic                unused_s;

  generate
    if (DWIDTH >= 72) begin : g_tag
      assign tag_in_s = m_axis_rc_tdata[71:64];
    end else begin : g_notag
      assign tag_in_s = 8'h00;
    end
  endgenerate

  assign sof_s       = m_axis_rc_tuser[32];
  assign push_s      = m_axis_rc_tvalid & tready_q & pcie_link_up;
  assign pop_s       = pcie_link_up & rc_cplr_ready & (count_q != '0);
  assign full_s      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign wr_en_s     = push_s & (~full_s | pop_s);
  assign ovf_s       = push_s & full_s & ~pop_s;
  assign pop_entry_s = mem_q[rd_ptr_q];
  assign pop_ex_s    = pop_entry_s[EW-1 -: 16];
  assign unused_s    = ^{m_axis_rc_tuser[74:43], m_axis_rc_tuser[41:33], m_axis_rc_tuser[31:0]};

`ifdef RC_PARITY_CHK_EN
  logic [3:0] par_cnt_q;
  assign par_bad_s = par_mismatch(m_axis_rc_tdata, m_axis_rc_tuser[74:43]);
  assign par_cnt_s = par_cnt_q;

  // Saturating count of accepted beats with a parity mismatch.
  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      par_cnt_q <= 4'h0;
    end else if (push_s && par_bad_s && (par_cnt_q != 4'hF)) begin
      par_cnt_q <= par_cnt_q + 4'h1;
    end
  end
`else
  assign par_bad_s = 1'b0;
  assign par_cnt_s = 4'h0;
`endif

  // Packet framing state register.
  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next packet state; a link drop abandons any partial packet.
  always_comb begin
    state_d = state_q;
    if (!pcie_link_up) begin
      state_d = IDLE;
    end else if (push_s) begin
      state_d = m_axis_rc_tlast ? IDLE : IN_PKT;
    end else begin
      state_d = state_q;
    end
  end

  // Write-time sideband: sop, eop, sticky error, last valid DW index and tag.
  always_comb begin
    sop_s       = 1'b1;
    frame_err_s = 1'b0;
    case (state_q)
      IDLE: begin
        sop_s       = 1'b1;
        frame_err_s = ~sof_s;
      end
      IN_PKT: begin
        sop_s       = sof_s;
        frame_err_s = sof_s;
      end
      default: begin
        sop_s       = 1'b1;
        frame_err_s = 1'b1;
      end
    endcase
    tag_s = sop_s ? tag_in_s : tag_q;
    err_s = m_axis_rc_tuser[42] | (sop_s & (m_axis_rc_tdata[45:43] != 3'd0)) | frame_err_s |
            (m_axis_rc_tkeep == '0) | par_bad_s | (~sop_s & err_q);
    ex_s  = {sop_s, m_axis_rc_tlast, err_s, keep_mod(m_axis_rc_tkeep), tag_s};
  end

  // Per-packet sticky error and captured tag.
  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      err_q <= 1'b0;
      tag_q <= 8'h00;
    end else if (push_s) begin
      err_q <= err_s;
      tag_q <= tag_s;
    end
  end

  // FIFO pointer, occupancy and ready computation.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (!pcie_link_up) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_en_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_s   ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({wr_en_s, pop_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
    tready_d = pcie_link_up &
               (({1'b0, count_q} + (AW+2)'(push_s)) < (AW+2)'(THRESH));
  end

  // Statistics next-state: wrapping packet count, saturating error count.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (pop_s && pop_ex_s[14]) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
      if (pop_ex_s[13] && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      else                                          err_cnt_d = err_cnt_q;
    end else begin
      pkt_cnt_d = pkt_cnt_q;
      err_cnt_d = err_cnt_q;
    end
  end

  // Beat storage; contents are qualified by the pointers so no reset needed.
  always_ff @(posedge pcie_clk) begin
    if (wr_en_s) mem_q[wr_ptr_q] <= {ex_s, m_axis_rc_tdata};
  end

  // FIFO control, output beat register and statistics.
  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tready_q   <= 1'b0;
      wen_q      <= 1'b0;
      out_data_q <= '0;
      out_ex_q   <= 16'h0000;
      pkt_cnt_q  <= 32'd0;
      err_cnt_q  <= 16'd0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tready_q   <= tready_d;
      wen_q      <= pop_s;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      ovf_q      <= ovf_q | ovf_s;
      if (pop_s) begin
        out_data_q <= pop_entry_s[DWIDTH-1:0];
        out_ex_q   <= pop_ex_s;
      end
    end
  end

  assign m_axis_rc_tready = tready_q;
  assign rc_cplr_wen      = wen_q;
  assign rc_cplr_data     = out_data_q;
  assign rc_cplr_data_ex  = out_ex_q;
  assign cpl_pkt_cnt      = pkt_cnt_q;
  assign cpl_err_cnt      = err_cnt_q;
  assign fifo_level       = count_q;
  assign odbg_info        = {state_q, par_cnt_s, 6'(count_q), ovf_q, rc_cplr_ready, tready_q, pcie_link_up};

endmodule

// File: tb/tb_pcie_rc_cpl_rx.sv
// Directed, table-driven bench for pcie_rc_cpl_rx (default parameters).
module tb_pcie_rc_cpl_rx;
  logic         clk = 1'b0;
  logic         rst;
  logic         link_up;
  logic [255:0] tdata;
  logic [74:0]  tuser;
  logic         tlast;
  logic [7:0]   tkeep;
  logic         tvalid;
  logic         tready;
  logic [15:0]  ex;
  logic [255:0] odata;
  logic         wen;
  logic         cready;
  logic [31:0]  pkt_cnt;
  logic [15:0]  err_cnt;
  logic [4:0]   level;
  logic [15:0]  odbg;

  int total = 0;
  int bad   = 0;
  logic [15:0] out_ex[$];
  logic [15:0] out_seq[$];

  pcie_rc_cpl_rx dut (
    .pcie_clk(clk), .pcie_rst(rst), .pcie_link_up(link_up),
    .m_axis_rc_tdata(tdata), .m_axis_rc_tuser(tuser), .m_axis_rc_tlast(tlast),
    .m_axis_rc_tkeep(tkeep), .m_axis_rc_tvalid(tvalid), .m_axis_rc_tready(tready),
    .rc_cplr_data_ex(ex), .rc_cplr_data(odata), .rc_cplr_wen(wen),
    .rc_cplr_ready(cready), .cpl_pkt_cnt(pkt_cnt), .cpl_err_cnt(err_cnt),
    .fifo_level(level), .odbg_info(odbg)
  );

  always #5 clk = ~clk;

  // Output beat monitor.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      out_ex.push_back(ex);
      out_seq.push_back(odata[15:0]);
    end
  end

  typedef struct {
    logic       sof;
    logic       last;
    logic [7:0] keep;
    logic [2:0] st;
    logic [7:0] tag;
    logic       disc;
    logic [15:0] exp_ex;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] get_ex(input int idx);
    if (idx < out_ex.size()) return out_ex[idx];
    return 16'hxxxx;
  endfunction

  function automatic logic [15:0] get_seq(input int idx);
    if (idx < out_seq.size()) return out_seq[idx];
    return 16'hxxxx;
  endfunction

  task automatic drive(input logic sof, input logic last, input logic [7:0] keep, input logic [2:0] st,
                       input logic [7:0] tag, input logic disc, input logic [15:0] seq, input logic flip);
    logic [255:0] d;
    logic [31:0]  p;
    d = '0;
    d[15:0]  = seq;
    d[45:43] = st;
    d[71:64] = tag;
    for (int i = 0; i < 32; i++) p[i] = ~^d[8*i +: 8];
    p[0]  = p[0] ^ flip;
    tdata = d;
    tuser = {p, disc, 9'd0, sof, 32'hFFFF_FFFF};
    tlast = last;
    tkeep = keep;
  endtask

  task automatic send_beat(input logic sof, input logic last, input logic [7:0] keep, input logic [2:0] st,
                           input logic [7:0] tag, input logic disc, input logic [15:0] seq, input logic flip);
    logic pre;
    logic acc;
    drive(sof, last, keep, st, tag, disc, seq, flip);
    tvalid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); pre = tready;
      @(posedge clk); #1;
      if (pre) begin acc = 1'b1; break; end
    end
    tvalid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no accept expected accept for seq %0h", seq);
    end
  endtask

  initial begin
    int base;
    int idx;
    int n0;
    logic pre;

    tbl[0]  = '{1'b1, 1'b0, 8'hFF, 3'd0, 8'h5A, 1'b0, 16'h875A};
    tbl[1]  = '{1'b0, 1'b0, 8'hFF, 3'd0, 8'h5A, 1'b0, 16'h075A};
    tbl[2]  = '{1'b0, 1'b1, 8'h07, 3'd0, 8'h5A, 1'b0, 16'h425A};
    tbl[3]  = '{1'b1, 1'b0, 8'hFF, 3'd1, 8'h11, 1'b0, 16'hA711};
    tbl[4]  = '{1'b0, 1'b1, 8'h0F, 3'd0, 8'h11, 1'b0, 16'h6311};
    tbl[5]  = '{1'b1, 1'b0, 8'hFF, 3'd0, 8'h22, 1'b0, 16'h8722};
    tbl[6]  = '{1'b1, 1'b0, 8'hFF, 3'd0, 8'h33, 1'b0, 16'hA733};
    tbl[7]  = '{1'b0, 1'b1, 8'h01, 3'd0, 8'h33, 1'b0, 16'h6033};
    tbl[8]  = '{1'b0, 1'b1, 8'h03, 3'd0, 8'h44, 1'b0, 16'hE144};
    tbl[9]  = '{1'b1, 1'b1, 8'h00, 3'd0, 8'h55, 1'b0, 16'hE055};
    tbl[10] = '{1'b1, 1'b1, 8'hFF, 3'd0, 8'h66, 1'b1, 16'hE766};
    tbl[11] = '{1'b1, 1'b1, 8'hFF, 3'd0, 8'h77, 1'b0, 16'hC777};
    tbl[12] = '{1'b1, 1'b0, 8'hFF, 3'd0, 8'h88, 1'b0, 16'h8788};
    tbl[13] = '{1'b0, 1'b1, 8'hFF, 3'd7, 8'h99, 1'b0, 16'h4788};

    rst = 1'b1; link_up = 1'b1; cready = 1'b1; tvalid = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_wen",    64'(wen), 64'd0);
    chk("rst_level",  64'(level), 64'd0);
    chk("rst_pkt",    64'(pkt_cnt), 64'd0);
    chk("rst_err",    64'(err_cnt), 64'd0);
    chk("rst_ex",     64'(ex), 64'd0);
    chk("rst_odbg",   64'(odbg), 64'h0005);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Two-cycle latency from beat presentation to wen.
    drive(1'b1, 1'b1, 8'hFF, 3'd0, 8'h01, 1'b0, 16'h0001, 1'b0);
    tvalid = 1'b1;
    @(negedge clk); chk("lat_tready", 64'(tready), 64'd1);
    @(posedge clk); #1 tvalid = 1'b0;
    @(negedge clk); chk("lat_wen_c1", 64'(wen), 64'd0);
    @(negedge clk); chk("lat_wen_c2", 64'(wen), 64'd1);
    chk("lat_ex", 64'(ex), 64'hC701);
    repeat (3) @(posedge clk); #1;

    // Table: consumer always ready.
    base = out_ex.size();
    for (int i = 0; i < 14; i++)
      send_beat(tbl[i].sof, tbl[i].last, tbl[i].keep, tbl[i].st, tbl[i].tag, tbl[i].disc, 16'h0100 + 16'(i), 1'b0);
    repeat (10) @(posedge clk); #1;
    chk("tbl_count", 64'(out_ex.size() - base), 64'd14);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("tbl_ex[%0d]", i), 64'(get_ex(base + i)), 64'(tbl[i].exp_ex));
      chk($sformatf("tbl_seq[%0d]", i), 64'(get_seq(base + i)), 64'(16'h0100 + 16'(i)));
    end
    chk("tbl_pkt", 64'(pkt_cnt), 64'd9);
    chk("tbl_err", 64'(err_cnt), 64'd5);

    // Backpressure: 20 beats against a stalled consumer.
    cready = 1'b0;
    base = out_ex.size();
    idx = 0;
    drive(1'b1, 1'b0, 8'hFF, 3'd0, 8'hB2, 1'b0, 16'h0200, 1'b0);
    tvalid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); pre = tready;
      @(posedge clk); #1;
      if (pre && tvalid) begin
        idx++;
        if (idx < 20) drive(1'b0, idx == 19, 8'hFF, 3'd0, 8'hB2, 1'b0, 16'h0200 + 16'(idx), 1'b0);
        else tvalid = 1'b0;
      end
    end
    chk("bp_accepted", 64'(idx), 64'd12);
    @(negedge clk);
    chk("bp_level", 64'(level), 64'd12);
    chk("bp_tready", 64'(tready), 64'd0);
    chk("bp_ovf", 64'(odbg[3]), 64'd0);
    cready = 1'b1;
    for (int c = 0; c < 200 && idx < 20; c++) begin
      @(negedge clk); pre = tready;
      @(posedge clk); #1;
      if (pre && tvalid) begin
        idx++;
        if (idx < 20) drive(1'b0, idx == 19, 8'hFF, 3'd0, 8'hB2, 1'b0, 16'h0200 + 16'(idx), 1'b0);
        else tvalid = 1'b0;
      end
    end
    tvalid = 1'b0;
    repeat (40) @(posedge clk); #1;
    chk("bp_total", 64'(idx), 64'd20);
    chk("bp_count", 64'(out_ex.size() - base), 64'd20);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("bp_seq[%0d]", i), 64'(get_seq(base + i)), 64'(16'h0200 + 16'(i)));
      chk($sformatf("bp_ex[%0d]", i), 64'(get_ex(base + i)),
          (i == 0) ? 64'h87B2 : ((i == 19) ? 64'h47B2 : 64'h07B2));
    end
    chk("bp_pkt", 64'(pkt_cnt), 64'd10);
    chk("bp_level_end", 64'(level), 64'd0);

    // Link down with six beats queued and one pop in flight.
    cready = 1'b0;
    for (int i = 0; i < 6; i++)
      send_beat(i == 0, 1'b0, 8'hFF, 3'd0, 8'hD0, 1'b0, 16'h0300 + 16'(i), 1'b0);
    @(negedge clk);
    chk("ld_level_q", 64'(level), 64'd6);
    n0 = out_ex.size();
    cready = 1'b1;
    @(posedge clk); #1 link_up = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ld_wen", 64'(wen), 64'd0);
    chk("ld_level", 64'(level), 64'd0);
    chk("ld_tready", 64'(tready), 64'd0);
    repeat (5) @(negedge clk);
    chk("ld_beats_out", 64'(out_ex.size() - n0), 64'd1);
    chk("ld_pkt", 64'(pkt_cnt), 64'd10);
    chk("ld_err", 64'(err_cnt), 64'd5);
    @(posedge clk); #1 link_up = 1'b1;
    base = out_ex.size();
    send_beat(1'b1, 1'b0, 8'hFF, 3'd0, 8'hAB, 1'b0, 16'h0400, 1'b0);
    send_beat(1'b0, 1'b1, 8'hFF, 3'd0, 8'hAB, 1'b0, 16'h0401, 1'b0);
    repeat (10) @(posedge clk); #1;
    chk("lu_ex0", 64'(get_ex(base)), 64'h87AB);
    chk("lu_ex1", 64'(get_ex(base + 1)), 64'h47AB);
    chk("lu_pkt", 64'(pkt_cnt), 64'd11);

    // Byte-0 parity flipped on the middle beat.
    base = out_ex.size();
    send_beat(1'b1, 1'b0, 8'hFF, 3'd0, 8'hC3, 1'b0, 16'h0500, 1'b0);
    send_beat(1'b0, 1'b0, 8'hFF, 3'd0, 8'hC3, 1'b0, 16'h0501, 1'b1);
    send_beat(1'b0, 1'b1, 8'hFF, 3'd0, 8'hC3, 1'b0, 16'h0502, 1'b0);
    repeat (10) @(posedge clk); #1;
    chk("par_ex0", 64'(get_ex(base)), 64'h87C3);
`ifdef RC_PARITY_CHK_EN
    chk("par_ex1", 64'(get_ex(base + 1)), 64'h27C3);
    chk("par_ex2", 64'(get_ex(base + 2)), 64'h67C3);
    chk("par_cnt", 64'(odbg[13:10]), 64'd1);
    chk("par_err", 64'(err_cnt), 64'd6);
`else
    chk("par_ex1", 64'(get_ex(base + 1)), 64'h07C3);
    chk("par_ex2", 64'(get_ex(base + 2)), 64'h47C3);
    chk("par_cnt", 64'(odbg[13:10]), 64'd0);
    chk("par_err", 64'(err_cnt), 64'd5);
`endif
    chk("par_pkt", 64'(pkt_cnt), 64'd12);

    // Asynchronous reset with a partial packet queued.
    cready = 1'b0;
    send_beat(1'b1, 1'b0, 8'hFF, 3'd0, 8'hE1, 1'b0, 16'h0600, 1'b0);
    @(negedge clk);
    chk("ar_level_pre", 64'(level), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_level", 64'(level), 64'd0);
    chk("ar_tready", 64'(tready), 64'd0);
    chk("ar_pkt", 64'(pkt_cnt), 64'd0);
    chk("ar_err", 64'(err_cnt), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pcie_rc_cpl_rx.md
Name: pcie_rc_cpl_rx

Overview:
Receives requester-completion (RC) TLP beats from the Xilinx Gen3 PCIe core AXI-Stream RC interface (DWord-aligned, non-straddled) and forwards them to the pcie_cplr_asm side. It replaces the one-register, ready-follows-ready pass-through with a parametrised skid FIFO that fully decouples core backpressure from consumer backpressure. It also adds packet-boundary tracking, tag capture, completion-status error flagging, link-down flush and statistics counters.

Parameters:
DWIDTH, 256, data width in bits; legal values 64, 128, 256.
FIFO_DEPTH, 16, beat FIFO entries; power of 2, minimum 8.
AFULL_MARGIN, 4, free entries reserved to absorb in-flight beats after tready deasserts; minimum 3, less than FIFO_DEPTH.

Ports:
pcie_clk  input  1  core user clock.
pcie_rst  input  1  asynchronous, active-high reset.
pcie_link_up  input  1  core link status; low forces a flush.
m_axis_rc_tdata  input  DWIDTH  RC beat data.
m_axis_rc_tuser  input  75  byte_en[31:0], is_sof0[32], discontinue[42], parity[74:43].
m_axis_rc_tlast  input  1  last beat of TLP.
m_axis_rc_tkeep  input  DWIDTH/32  DW valid mask.
m_axis_rc_tvalid  input  1  beat valid.
m_axis_rc_tready  output  1  registered ready to the core.
rc_cplr_data_ex  output  16  sideband for the output beat.
rc_cplr_data  output  DWIDTH  output beat data.
rc_cplr_wen  output  1  one-cycle strobe per output beat.
rc_cplr_ready  input  1  consumer can accept a beat this cycle.
cpl_pkt_cnt  output  32  completed TLPs forwarded, wrapping.
cpl_err_cnt  output  16  TLPs with err set, saturating.
fifo_level  output  log2(FIFO_DEPTH)+1  current occupancy.
odbg_info  output  16  {state[1:0], parity_err_cnt[3:0], fifo_level[5:0] zero-extended, ovf_sticky, rc_cplr_ready, m_axis_rc_tready, pcie_link_up}.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, counters 0.
- Input accept: a beat is accepted when m_axis_rc_tvalid & m_axis_rc_tready.
- Ready: m_axis_rc_tready <= pcie_link_up & (fifo_level + pending < FIFO_DEPTH - AFULL_MARGIN), registered one cycle.
  - Beats arriving while ready is low are not accepted.
  - The margin guarantees no overflow. If an overflow ever occurs, the beat is dropped and ovf_sticky is set; ovf_sticky clears on reset only.
- Input FSM, IDLE -> IN_PKT:
  - IDLE -> IN_PKT on an accepted beat with is_sof0 and !tlast.
  - IN_PKT -> IDLE on an accepted tlast beat.
  - Beat in IDLE without sof0 is a framing error: it is stored with err=1 and sop forced to 1.
  - sof0 while in IN_PKT is a framing error: the new beat is stored with sop=1 and err=1.
- Sideband computed at write time and stored with the data in the FIFO:
  - ex[15] = sop.
  - ex[14] = tlast.
  - ex[13] = err = discontinue | (sop & completion status tdata[45:43] != 0) | framing error. On non-sop beats, err carries the sticky err of the current packet.
  - ex[12:8] = mod = index of the highest set tkeep bit, zero-extended. All-zero tkeep gives mod 0 and err=1.
  - ex[7:0] = tag = tdata[71:64], captured on the sop beat and repeated on every beat of that TLP.
- Output side:
  - When FIFO non-empty and rc_cplr_ready=1, pop one entry.
  - Next cycle: rc_cplr_wen=1, rc_cplr_data/ex = entry.
  - rc_cplr_wen=0 otherwise; data and ex hold their last value.
- Latency: accept to wen = 2 cycles minimum (FIFO write, then registered pop).
- Simultaneous push and pop: level unchanged; supported at full rate, one beat per cycle.
- Counters:
  - cpl_pkt_cnt increments when an eop beat is popped.
  - cpl_err_cnt increments when a popped eop beat has err=1, saturating at 16'hFFFF.
- Link down (pcie_link_up=0), synchronous effect:
  - FIFO pointers cleared and state IDLE; tready deasserted next cycle.
  - A pop in flight completes; no further wen.
  - Counters retained.
- Asynchronous reset mid-packet: everything returns to reset values immediately; a partial packet is discarded.

Optional Feature:
RC_PARITY_CHK_EN:
- With the macro defined: each accepted beat is checked for odd parity per byte against tuser parity, for the lower DWIDTH/8 bits only.
  - Any mismatch sets err for that beat and the rest of the packet.
  - Each mismatch increments a 4-bit saturating parity_err_cnt, exposed in odbg_info.
- Without the macro: the parity field is ignored and parity_err_cnt reads 0.

Test Plan:
1. Single 3-beat TLP, sof0 on beat 0, tag 8'h5A, status 0, last tkeep 8'h07, consumer always ready -> 3 wen pulses starting 2 cycles after the first accept; ex[15] on beat 0, ex[14] on beat 2, mod=2 on beat 2, tag 5A on all beats, err=0, cpl_pkt_cnt=1.
2. Consumer holds rc_cplr_ready=0 while the core streams 20 back-to-back beats, FIFO_DEPTH 16 -> tready drops when level reaches 12, no overflow (ovf_sticky=0); after release, all accepted beats are output in order.
3. Completion with status 3'b001 (UR) -> err=1 on every beat of that TLP, cpl_err_cnt=1.
4. sof0 asserted mid-packet -> new beat has sop=1 and err=1; the next eop closes the packet; cpl_err_cnt increments.
5. pcie_link_up drops with 6 beats queued -> no further wen after at most 1 cycle, fifo_level=0 next cycle, tready=0; after link_up returns, a new TLP passes cleanly.
6. RC_PARITY_CHK_EN defined, byte 0 parity bit flipped on beat 1 -> err=1 on beats 1 through eop, parity_err_cnt=1; without the macro -> err=0.
